// File: rtl/microop_sequencer_pkg.sv
// microop_sequencer_pkg: microcode word layout and encodings shared by the microcode store and the sequencer
package microop_sequencer_pkg;
  localparam int OPCODE_W = 6;
  localparam int COUNT_W = 5;
  localparam int UADDR_W = 1 + OPCODE_W + COUNT_W;
  localparam logic [5:0] OP_RESET = 6'd0;
  localparam logic [5:0] OP_FETCH = 6'd1;
  typedef enum logic [3:0] {OUT_NONE = 4'd0, OUT_CTRL = 4'd8} out_plane_t;
  typedef enum logic [2:0] {
    IN_NONE = 3'd0, IN_REG = 3'd1, IN_TMP0 = 3'd2, IN_TMP1 = 3'd3,
    IN_MMU = 3'd4, IN_OPWORD = 3'd5, IN_OPCODE = 3'd6
  } in_plane_t;
  typedef enum logic [1:0] {REG_SEL_RS = 2'd0, REG_SEL_RT = 2'd1, REG_SEL_RD = 2'd2, REG_SEL_CTRL = 2'd3} reg_sel_t;
  typedef enum logic [1:0] {COND_SEL_ZERO = 2'd0, COND_SEL_CARRY = 2'd1, COND_SEL_NEG = 2'd2, COND_SEL_IRQ = 2'd3} cond_sel_t;
  typedef enum logic {MISC_NEXT = 1'b0, MISC_RESTART = 1'b1} misc_t;
  typedef enum logic {OPCODE_SEL_OPWORD = 1'b0, OPCODE_SEL_BUS = 1'b1} opcode_sel_t;
  typedef struct packed {
    logic [3:0] rsvd_hi;
    logic [1:0] cond_var_sel;
    logic       opcode_sel;
    logic [6:0] rsvd_mid;
    logic       misc;
    logic [2:0] in_plane;
    logic [3:0] out_plane;
    logic [1:0] reg_sel;
    logic [7:0] ctrl_data;
  } ucode_t;
endpackage

// File: rtl/microop_sequencer_if.sv
// microop_sequencer_if: microcode store, datapath and strobe signals around the sequencer
interface microop_sequencer_if
  import microop_sequencer_pkg::*;
#(parameter int UADDR_WIDTH = UADDR_W);
  logic                   STALL;
  logic [31:0]            UCODE;
  logic [31:0]            OPWORD;
  logic [31:0]            BUS;
  logic                   MLU_ZERO;
  logic                   MLU_CARRY;
  logic                   MLU_NEGATIVE;
  logic                   INTERRUPT;
  logic [UADDR_WIDTH-1:0] UADDR;
  logic [4:0]             REG_IDX;
  logic                   CTRL_BUS_OE;
  logic [31:0]            CTRL_BUS_DATA;
  logic                   REG_WE;
  logic                   TMP0_WE;
  logic                   TMP1_WE;
  logic                   MMU_WE;
  logic                   OPWORD_WE;
  logic                   UOP_OVERFLOW;
  modport master (
    output STALL, UCODE, OPWORD, BUS, MLU_ZERO, MLU_CARRY, MLU_NEGATIVE, INTERRUPT,
    input  UADDR, REG_IDX, CTRL_BUS_OE, CTRL_BUS_DATA, REG_WE, TMP0_WE, TMP1_WE, MMU_WE, OPWORD_WE, UOP_OVERFLOW
  );
  modport slave (
    input  STALL, UCODE, OPWORD, BUS, MLU_ZERO, MLU_CARRY, MLU_NEGATIVE, INTERRUPT,
    output UADDR, REG_IDX, CTRL_BUS_OE, CTRL_BUS_DATA, REG_WE, TMP0_WE, TMP1_WE, MMU_WE, OPWORD_WE, UOP_OVERFLOW
  );
endinterface

// File: rtl/microop_sequencer_sync2.sv
// sync2: two-flop synchroniser for an asynchronous single-bit input
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/microop_sequencer.sv
// microop_sequencer: forms the microcode address from opcode/count/condition and decodes the returned microcode word
module microop_sequencer
  import microop_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_W,
  parameter int COUNT_WIDTH = COUNT_W,
  localparam int UADDR_WIDTH = 1 + OPCODE_WIDTH + COUNT_WIDTH
) (
  input logic CLK,
  input logic RST,
  microop_sequencer_if.slave seq
);
  ucode_t u;
  logic [OPCODE_WIDTH-1:0] opcode, opcode_nx;
  logic [COUNT_WIDTH-1:0] count, count_nx;
  logic cond_var, cond_nx, ovf, ovf_nx, irq_sync;
  assign u = seq.UCODE;
  sync2 u_irq_sync (.clk(CLK), .rst(RST), .d(seq.INTERRUPT), .q(irq_sync));
  always_comb begin
    count_nx = u.misc == MISC_RESTART ? '0 : count + 1'b1;
    opcode_nx = u.in_plane != IN_OPCODE ? opcode :
                u.opcode_sel == OPCODE_SEL_BUS ? seq.BUS[OPCODE_WIDTH-1:0] : seq.OPWORD[31 -: OPCODE_WIDTH];
    cond_nx = u.cond_var_sel == COND_SEL_ZERO ? seq.MLU_ZERO :
              u.cond_var_sel == COND_SEL_CARRY ? seq.MLU_CARRY :
              u.cond_var_sel == COND_SEL_NEG ? seq.MLU_NEGATIVE : irq_sync;
    ovf_nx = ovf | (u.misc == MISC_NEXT && &count);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      opcode <= OPCODE_WIDTH'(OP_RESET);
      count <= '0;
      cond_var <= 1'b0;
      ovf <= 1'b0;
    end else if (!seq.STALL) begin
      opcode <= opcode_nx;
      count <= count_nx;
      cond_var <= cond_nx;
      ovf <= ovf_nx;
    end
  assign seq.UADDR = {cond_var, opcode, count};
  assign seq.UOP_OVERFLOW = ovf;
  assign seq.REG_IDX = u.reg_sel == REG_SEL_RS ? seq.OPWORD[25:21] :
                       u.reg_sel == REG_SEL_RT ? seq.OPWORD[20:16] :
                       u.reg_sel == REG_SEL_RD ? seq.OPWORD[15:11] : u.ctrl_data[4:0];
  assign seq.CTRL_BUS_OE = u.out_plane == OUT_CTRL;
  assign seq.CTRL_BUS_DATA = {24'd0, u.ctrl_data};
  assign seq.REG_WE = !seq.STALL && u.in_plane == IN_REG;
  assign seq.TMP0_WE = !seq.STALL && u.in_plane == IN_TMP0;
  assign seq.TMP1_WE = !seq.STALL && u.in_plane == IN_TMP1;
  assign seq.MMU_WE = !seq.STALL && u.in_plane == IN_MMU;
  assign seq.OPWORD_WE = !seq.STALL && u.in_plane == IN_OPWORD;
  wire unused_bits = ^{u.rsvd_hi, u.rsvd_mid, seq.OPWORD, seq.BUS};
endmodule

// File: tb/tb_microop_sequencer.sv
// tb_microop_sequencer: directed stimulus with a behavioural model checked every negedge plus literal checkpoints
module tb_microop_sequencer;
  logic CLK = 1'b0;
  logic RST;
  int n_pass = 0, n_tot = 0;
  int m_op = 0, m_cnt = 0, m_cond = 0, m_ovf = 0;
  int irq_hist[3] = '{0, 0, 0};
  localparam logic [31:0] JUNK = 32'hA07C_0000;

  microop_sequencer_if sif ();
  microop_sequencer dut (.CLK(CLK), .RST(RST), .seq(sif.slave));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] uc(input int cs, input int os, input int mi, input int ip,
                                     input int op, input int rs, input int cd);
    return JUNK | (32'(cs) << 26) | (32'(os) << 25) | (32'(mi) << 17) | (32'(ip) << 14) |
           (32'(op) << 10) | (32'(rs) << 8) | 32'(cd & 255);
  endfunction

  // model: the interrupt value selectable now is the one sampled two edges ago
  always @(posedge CLK or posedge RST)
    if (RST) begin
      m_op <= 0; m_cnt <= 0; m_cond <= 0; m_ovf <= 0;
      irq_hist <= '{0, 0, 0};
    end else begin
      int ip, cs, flag;
      ip = int'((sif.UCODE >> 14) & 7);
      cs = int'((sif.UCODE >> 26) & 3);
      flag = cs == 0 ? int'(sif.MLU_ZERO) : cs == 1 ? int'(sif.MLU_CARRY) :
             cs == 2 ? int'(sif.MLU_NEGATIVE) : irq_hist[1];
      irq_hist <= '{int'(sif.INTERRUPT), irq_hist[0], irq_hist[1]};
      if (!sif.STALL) begin
        m_cond <= flag;
        if (ip == 6) m_op <= sif.UCODE[25] ? int'(sif.BUS % 64) : int'(sif.OPWORD / 67108864);
        if (sif.UCODE[17]) m_cnt <= 0;
        else if (m_cnt + 1 == 32) begin m_cnt <= 0; m_ovf <= 1; end
        else m_cnt <= m_cnt + 1;
      end
    end

  always @(negedge CLK) begin
    int ip, rs, op, ridx, stb;
    ip = int'((sif.UCODE >> 14) & 7);
    rs = int'((sif.UCODE >> 8) & 3);
    op = int'((sif.UCODE >> 10) & 15);
    ridx = rs == 0 ? int'((sif.OPWORD >> 21) & 31) : rs == 1 ? int'((sif.OPWORD >> 16) & 31) :
           rs == 2 ? int'((sif.OPWORD >> 11) & 31) : int'(sif.UCODE & 31);
    stb = (sif.STALL || ip < 1 || ip > 5) ? 0 : 1 << (5 - ip);
    chk("uaddr", 32'(sif.UADDR), 32'(m_cond * 2048 + m_op * 32 + m_cnt));
    chk("reg_idx", 32'(sif.REG_IDX), 32'(ridx));
    chk("bus_oe", 32'(sif.CTRL_BUS_OE), 32'(op == 8));
    chk("bus_data", sif.CTRL_BUS_DATA, sif.UCODE & 32'hFF);
    chk("strobes", 32'({sif.REG_WE, sif.TMP0_WE, sif.TMP1_WE, sif.MMU_WE, sif.OPWORD_WE}), 32'(stb));
    chk("overflow", 32'(sif.UOP_OVERFLOW), 32'(m_ovf));
  end

  task automatic step(input logic [31:0] w);
    sif.UCODE = w;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    #2;
    chk("rst_async_uaddr", 32'(sif.UADDR), 32'h0);
    @(posedge CLK);
    #1 RST = 1'b0;
    #1 chk("rst_release_uaddr", 32'(sif.UADDR), 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    sif.STALL = 1'b0; sif.UCODE = uc(0, 0, 0, 0, 0, 0, 0); sif.OPWORD = '0; sif.BUS = '0;
    sif.MLU_ZERO = 1'b0; sif.MLU_CARRY = 1'b0; sif.MLU_NEGATIVE = 1'b0; sif.INTERRUPT = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk("reset_uaddr", 32'(sif.UADDR), 32'h0);
    RST = 1'b0;
    #1 chk("first_cycle_uaddr", 32'(sif.UADDR), 32'h0);
    sif.OPWORD = 32'h2000_0000;
    step(uc(0, 0, 1, 6, 0, 0, 0));
    chk("fetch_uaddr", 32'(sif.UADDR), 32'h100);
    repeat (3) step(uc(0, 0, 0, 0, 0, 0, 0));
    chk("count3_uaddr", 32'(sif.UADDR), 32'h103);
    pulse_reset();
    step(uc(0, 0, 1, 6, 0, 0, 0));
    repeat (2) step(uc(0, 0, 0, 0, 0, 0, 0));
    sif.MLU_ZERO = 1'b1;
    step(uc(0, 0, 0, 0, 0, 0, 0));
    chk("branch_taken", 32'(sif.UADDR), 32'h903);
    sif.MLU_ZERO = 1'b0;
    step(uc(0, 0, 0, 0, 0, 0, 0));
    chk("branch_not_taken", 32'(sif.UADDR), 32'h104);
    sif.UCODE = uc(0, 0, 0, 0, 0, 3, 8'h1F);
    #1 chk("reg_idx_ctrl", 32'(sif.REG_IDX), 32'd31);
    sif.OPWORD = 32'h2000_0000 | (32'd5 << 11);
    sif.UCODE = uc(0, 0, 0, 0, 0, 2, 0);
    #1 chk("reg_idx_rd", 32'(sif.REG_IDX), 32'd5);
    sif.UCODE = uc(0, 0, 0, 0, 8, 0, 4);
    #1 chk("ctrl_oe", 32'(sif.CTRL_BUS_OE), 32'd1);
    chk("ctrl_data", sif.CTRL_BUS_DATA, 32'h4);
    sif.STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(uc(0, 0, 0, 1, 0, 0, 0));
      chk("stall_reg_we", 32'(sif.REG_WE), 32'd0);
      chk("stall_uaddr", 32'(sif.UADDR), 32'h104);
    end
    sif.STALL = 1'b0;
    #1 chk("unstall_reg_we", 32'(sif.REG_WE), 32'd1);
    step(uc(0, 0, 0, 1, 0, 0, 0));
    chk("unstall_advance", 32'(sif.UADDR), 32'h105);
    sif.BUS = 32'hFFFF_FF2A;
    step(uc(0, 1, 1, 6, 0, 0, 0));
    chk("bus_opcode", 32'(sif.UADDR), 32'h540);
    pulse_reset();
    repeat (31) step(uc(0, 0, 0, 0, 0, 0, 0));
    chk("count31_uaddr", 32'(sif.UADDR), 32'd31);
    chk("no_overflow_yet", 32'(sif.UOP_OVERFLOW), 32'd0);
    step(uc(0, 0, 0, 0, 0, 0, 0));
    chk("wrap_uaddr", 32'(sif.UADDR), 32'd0);
    chk("overflow_set", 32'(sif.UOP_OVERFLOW), 32'd1);
    repeat (3) step(uc(0, 0, 1, 0, 0, 0, 0));
    chk("overflow_sticky", 32'(sif.UOP_OVERFLOW), 32'd1);
    pulse_reset();
    chk("overflow_cleared", 32'(sif.UOP_OVERFLOW), 32'd0);
    sif.UCODE = uc(3, 0, 1, 0, 0, 0, 0);
    sif.INTERRUPT = 1'b1;
    step(uc(3, 0, 1, 0, 0, 0, 0));
    sif.INTERRUPT = 1'b0;
    chk("irq_edge1", 32'(sif.UADDR), 32'h0);
    step(uc(3, 0, 1, 0, 0, 0, 0));
    chk("irq_edge2", 32'(sif.UADDR), 32'h0);
    step(uc(3, 0, 1, 0, 0, 0, 0));
    chk("irq_edge3", 32'(sif.UADDR), 32'h800);
    step(uc(3, 0, 1, 0, 0, 0, 0));
    chk("irq_edge4", 32'(sif.UADDR), 32'h0);
    sif.INTERRUPT = 1'b1;
    sif.STALL = 1'b1;
    repeat (3) step(uc(3, 0, 1, 0, 0, 0, 0));
    sif.STALL = 1'b0;
    step(uc(3, 0, 1, 0, 0, 0, 0));
    chk("irq_sync_during_stall", 32'(sif.UADDR), 32'h800);
    @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
